// File: rtl/param_bank_pkg.sv
// Shared constants, FSM encoding and renderer field offsets for the
// parameter bank. PARAM_BANK_CHECKSUM_EN makes the last byte an XOR check byte.
package param_bank_pkg;

    localparam int NUM_BYTES = 55;
    localparam int IDX_W     = 6;
    localparam int EXP_W     = IDX_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECV    = 2'd1,
        PENDING = 2'd2
    } state_t;

    localparam int OFF_CAM_POS = 0;
    localparam int OFF_CAM_DIR = 6;
    localparam int OFF_LIGHT   = 12;
    localparam int OFF_COLOR   = 18;
    localparam int OFF_OBJECTS = 24;
    localparam int OFF_CHECK   = NUM_BYTES - 1;

endpackage

// File: rtl/param_bank_seq.sv
// Packet sequencer: in-order index tracking, pending/commit FSM and sticky
// error flags. PARAM_BANK_CHECKSUM_EN adds the running-XOR packet check.
module param_bank_seq
    import param_bank_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             update_reg,
    input  logic [IDX_W-1:0] idx,
    input  logic [7:0]       read_data,
    input  logic             pc_ready,
    input  logic             frame_sync,
    input  logic             err_clr,
    output logic             shadow_we,
    output logic [IDX_W-1:0] shadow_waddr,
    output logic             commit,
    output logic             busy,
    output logic             seq_err,
    output logic             overrun_err,
    output logic             chk_err
);

    state_t           state, state_n;
    logic [EXP_W-1:0] exp_q, exp_n;
    logic             set_seq, set_ovr, set_chk;
    logic             csum_ok;
    logic             first;

    assign first = update_reg && (idx == '0);
    assign busy  = (state != IDLE);

    always_comb begin
        state_n      = state;
        exp_n        = exp_q;
        shadow_we    = 1'b0;
        shadow_waddr = idx;
        commit       = 1'b0;
        set_seq      = 1'b0;
        set_ovr      = 1'b0;
        set_chk      = 1'b0;
        unique case (state)
            IDLE: begin
                if (first) begin
                    shadow_we = 1'b1;
                    exp_n     = EXP_W'(1);
                    state_n   = RECV;
                end else if (update_reg) begin
                    set_seq = 1'b1;
                end
                if (pc_ready) set_seq = 1'b1;
            end
            RECV: begin
                if (update_reg && pc_ready) begin
                    set_seq = 1'b1;
                    state_n = IDLE;
                end else if (update_reg) begin
                    // exp never exceeds NUM_BYTES, so this also rejects idx >= NUM_BYTES
                    if ({1'b0, idx} == exp_q && exp_q != EXP_W'(NUM_BYTES)) begin
                        shadow_we = 1'b1;
                        exp_n     = exp_q + EXP_W'(1);
                    end else if (idx == '0) begin
                        shadow_we = 1'b1;
                        exp_n     = EXP_W'(1);
                        set_seq   = 1'b1;
                    end else begin
                        set_seq = 1'b1;
                        state_n = IDLE;
                    end
                end else if (pc_ready) begin
                    if (exp_q != EXP_W'(NUM_BYTES)) begin
                        set_seq = 1'b1;
                        state_n = IDLE;
                    end else if (!csum_ok) begin
                        set_chk = 1'b1;
                        state_n = IDLE;
                    end else begin
                        state_n = PENDING;
                    end
                end
            end
            PENDING: begin
                if (frame_sync) begin
                    commit  = 1'b1;
                    state_n = IDLE;
                    if (first) begin
                        shadow_we = 1'b1;
                        exp_n     = EXP_W'(1);
                        state_n   = RECV;
                    end else if (update_reg) begin
                        set_seq = 1'b1;
                    end
                end else if (first) begin
                    shadow_we = 1'b1;
                    exp_n     = EXP_W'(1);
                    set_ovr   = 1'b1;
                    state_n   = RECV;
                end else if (update_reg) begin
                    set_seq = 1'b1;
                end
                if (pc_ready) set_seq = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            exp_q       <= '0;
            seq_err     <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            state       <= state_n;
            exp_q       <= exp_n;
            seq_err     <= set_seq | (seq_err & ~err_clr);
            overrun_err <= set_ovr | (overrun_err & ~err_clr);
        end
    end

`ifdef PARAM_BANK_CHECKSUM_EN
    logic [7:0] xor_q;

    // XOR over all bytes including the check byte is zero for a good packet
    assign csum_ok = (xor_q == 8'h00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xor_q   <= 8'h00;
            chk_err <= 1'b0;
        end else begin
            if (shadow_we)
                xor_q <= (shadow_waddr == '0) ? read_data : (xor_q ^ read_data);
            chk_err <= set_chk | (chk_err & ~err_clr);
        end
    end
`else
    logic unused_sig;

    assign csum_ok    = 1'b1;
    assign chk_err    = 1'b0;
    assign unused_sig = ^{read_data, set_chk};
`endif

endmodule

// File: rtl/param_bank.sv
// Double-buffered parameter bank: shadow fills from the UART assembler,
// active swaps in on frame_sync. PARAM_BANK_CHECKSUM_EN enables the check byte.
module param_bank
    import param_bank_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   update_reg,
    input  logic [IDX_W-1:0]       idx,
    input  logic [7:0]             read_data,
    input  logic                   pc_ready,
    input  logic                   frame_sync,
    input  logic                   err_clr,
    output logic [NUM_BYTES*8-1:0] params,
    output logic                   params_valid,
    output logic                   params_updated,
    output logic                   busy,
    output logic                   seq_err,
    output logic                   overrun_err,
    output logic                   chk_err
);

    logic                   shadow_we;
    logic [IDX_W-1:0]       shadow_waddr;
    logic                   commit;
    logic [NUM_BYTES*8-1:0] shadow;

    param_bank_seq u_seq (
        .clk          (clk),
        .reset        (reset),
        .update_reg   (update_reg),
        .idx          (idx),
        .read_data    (read_data),
        .pc_ready     (pc_ready),
        .frame_sync   (frame_sync),
        .err_clr      (err_clr),
        .shadow_we    (shadow_we),
        .shadow_waddr (shadow_waddr),
        .commit       (commit),
        .busy         (busy),
        .seq_err      (seq_err),
        .overrun_err  (overrun_err),
        .chk_err      (chk_err)
    );

    // Commit copies the pre-edge shadow even if byte 0 of the next packet lands now
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow         <= '0;
            params         <= '0;
            params_valid   <= 1'b0;
            params_updated <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_BYTES; k++) begin
                if (shadow_we && shadow_waddr == IDX_W'(k))
                    shadow[8*k +: 8] <= read_data;
            end
            if (commit) begin
                params       <= shadow;
                params_valid <= 1'b1;
            end
            params_updated <= commit;
        end
    end

endmodule

// File: tb/tb_param_bank.sv
// Scoreboard bench for param_bank: stimulus queues expected banks,
// a negedge monitor checks every swap and the held active bank.
module tb_param_bank;
    import param_bank_pkg::*;

    localparam int W = NUM_BYTES * 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             update_reg = 1'b0;
    logic [IDX_W-1:0] idx = '0;
    logic [7:0]       read_data = 8'h00;
    logic             pc_ready = 1'b0;
    logic             frame_sync = 1'b0;
    logic             err_clr = 1'b0;
    logic [W-1:0]     params;
    logic             params_valid;
    logic             params_updated;
    logic             busy;
    logic             seq_err;
    logic             overrun_err;
    logic             chk_err;

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] model = '0;
    logic         model_valid = 1'b0;
    logic         prev_upd = 1'b0;
    logic [7:0]   pkt[NUM_BYTES];

    param_bank dut (
        .clk            (clk),
        .reset          (reset),
        .update_reg     (update_reg),
        .idx            (idx),
        .read_data      (read_data),
        .pc_ready       (pc_ready),
        .frame_sync     (frame_sync),
        .err_clr        (err_clr),
        .params         (params),
        .params_valid   (params_valid),
        .params_updated (params_updated),
        .busy           (busy),
        .seq_err        (seq_err),
        .overrun_err    (overrun_err),
        .chk_err        (chk_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    task automatic cyc(input logic u, input int i, input logic [7:0] d,
                       input logic pc, input logic fs, input logic ec);
        update_reg = u;
        idx        = IDX_W'(i);
        read_data  = d;
        pc_ready   = pc;
        frame_sync = fs;
        err_clr    = ec;
        @(posedge clk);
        #1;
        update_reg = 1'b0;
        pc_ready   = 1'b0;
        frame_sync = 1'b0;
        err_clr    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) cyc(1'b1, i, pkt[i], 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pc();
        cyc(1'b0, 0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic fs();
        cyc(1'b0, 0, 8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic clr();
        cyc(1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic build(input logic [7:0] mul, input logic [7:0] add);
        for (int i = 0; i < NUM_BYTES; i++) pkt[i] = 8'(i) * mul + add;
`ifdef PARAM_BANK_CHECKSUM_EN
        pkt[NUM_BYTES-1] = 8'h00;
        for (int i = 0; i < NUM_BYTES - 1; i++)
            pkt[NUM_BYTES-1] = pkt[NUM_BYTES-1] ^ pkt[i];
`endif
    endtask

    function automatic logic [W-1:0] pkt_bits();
        logic [W-1:0] r;
        for (int k = 0; k < NUM_BYTES; k++) r[8*k +: 8] = pkt[k];
        return r;
    endfunction

    task automatic expect_swap();
        exp_q.push_back(pkt_bits());
    endtask

    always @(negedge clk) begin
        if (reset) begin
            model       = '0;
            model_valid = 1'b0;
            prev_upd    = 1'b0;
        end else begin
            if (params_updated) begin
                check("updated_one_clk", prev_upd, 1'b0);
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_swap: got swap, want none");
                end else begin
                    model       = exp_q.pop_front();
                    model_valid = 1'b1;
                end
            end
            prev_upd = params_updated;
            check("params", params, model);
            check("params_valid", params_valid, model_valid);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_params", params, '0);
        check("rst_valid", params_valid, 1'b0);
        check("rst_updated", params_updated, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_errs", {seq_err, overrun_err, chk_err}, 3'b000);
        reset = 1'b0;
        idle(2);

        // basic packet, swap 5 clk after pc_ready
        build(8'd1, 8'h10);
        send(0, NUM_BYTES - 1);
        pc();
        check("pend_busy", busy, 1'b1);
        idle(4);
        expect_swap();
        fs();
        check("t1_updated", params_updated, 1'b1);
        check("t1_byte0", params[7:0], 8'h10);
`ifndef PARAM_BANK_CHECKSUM_EN
        check("t1_byte54", params[8*54 +: 8], 8'h46);
`endif
        idle(1);
        check("t1_updated_low", params_updated, 1'b0);
        check("t1_valid", params_valid, 1'b1);
        check("t1_busy", busy, 1'b0);
        check("t1_errs", {seq_err, overrun_err, chk_err}, 3'b000);

        // pending packet held until frame_sync
        build(8'd3, 8'hA5);
        send(0, NUM_BYTES - 1);
        pc();
        idle(8);
        check("t2_busy", busy, 1'b1);
        expect_swap();
        fs();
        idle(1);

        // out-of-order index
        build(8'd2, 8'h01);
        send(0, 1);
        cyc(1'b1, 3, pkt[3], 1'b0, 1'b0, 1'b0);
        check("t3_seq_err", seq_err, 1'b1);
        check("t3_idle", busy, 1'b0);
        pc();
        check("t3_seq_hold", seq_err, 1'b1);
        fs();
        idle(1);
        clr();
        check("t3_seq_clr", seq_err, 1'b0);

        // overrun: packet B displaces pending A
        build(8'd5, 8'h33);
        send(0, NUM_BYTES - 1);
        pc();
        build(8'd7, 8'h02);
        send(0, 0);
        check("t4_overrun", overrun_err, 1'b1);
        check("t4_busy", busy, 1'b1);
        check("t4_no_seq", seq_err, 1'b0);
        send(1, NUM_BYTES - 1);
        pc();
        expect_swap();
        fs();
        idle(1);
        check("t4_overrun_sticky", overrun_err, 1'b1);
        clr();
        check("t4_overrun_clr", overrun_err, 1'b0);

        // pc_ready with frame_sync: no bypass
        build(8'd9, 8'h44);
        send(0, NUM_BYTES - 1);
        cyc(1'b0, 0, 8'h00, 1'b1, 1'b1, 1'b0);
        check("t5_pending", busy, 1'b1);
        idle(1);
        expect_swap();
        fs();
        idle(1);

`ifdef PARAM_BANK_CHECKSUM_EN
        for (int i = 0; i < NUM_BYTES; i++) pkt[i] = 8'h01;
        send(0, NUM_BYTES - 1);
        pc();
        check("t6_chk_err", chk_err, 1'b1);
        check("t6_idle", busy, 1'b0);
        fs();
        idle(1);
        clr();
        check("t6_chk_clr", chk_err, 1'b0);
        pkt[NUM_BYTES-1] = 8'h00;
        send(0, NUM_BYTES - 1);
        pc();
        check("t6_good_pending", busy, 1'b1);
        expect_swap();
        fs();
        idle(1);
`else
        check("t6_chk_tied", chk_err, 1'b0);
`endif

        // asynchronous reset mid-packet
        build(8'd11, 8'h07);
        send(0, 20);
        #2;
        reset = 1'b1;
        #1;
        check("t7_params", params, '0);
        check("t7_valid", params_valid, 1'b0);
        check("t7_busy", busy, 1'b0);
        check("t7_errs", {seq_err, overrun_err, chk_err}, 3'b000);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1);
        build(8'd13, 8'h21);
        send(0, NUM_BYTES - 1);
        pc();
        expect_swap();
        fs();
        idle(2);
        check("t7_errs_after", {seq_err, overrun_err, chk_err}, 3'b000);

        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
